// File: rtl/adex_neuron_array.sv
// adex_neuron_array
//   Time-multiplexed array of N_CH adaptive-exponential integrate-and-fire
//   neurons. One channel is updated per enabled cycle, round-robin, through
//   a single shared datapath. Each channel keeps its membrane u, its
//   adaptation w and its refractory counter r.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         update enable; low freezes all state and the pointer
//   current    per-channel input current, channel c at [c*W +: W]
//   spike      registered one-cycle spike pulse, one bit per channel
//   ch_idx     channel being updated this cycle
//   state_mon  stored membrane of channel ch_idx, before its update
module adex_neuron_array #(
    parameter int N_CH        = 4,
    parameter int W           = 8,
    parameter int THRESH      = 200,
    parameter int V_RESET     = 0,
    parameter int U_REST      = 0,
    parameter int THETA_RH    = 160,
    parameter int DT_SHIFT    = 3,
    parameter int LEAK_SHIFT  = 3,
    parameter int TAU_W_SHIFT = 4,
    parameter int B           = 8,
    parameter int REFRAC      = 2,
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [N_CH*W-1:0] current,
    output logic [N_CH-1:0]   spike,
    output logic [CW-1:0]     ch_idx,
    output logic [W-1:0]      state_mon
);

    localparam int SW = W + 3;

    localparam logic [W-1:0]  THRESH_V  = W'(THRESH);
    localparam logic [W-1:0]  V_RESET_V = W'(V_RESET);
    localparam logic [W-1:0]  U_REST_V  = W'(U_REST);
    localparam logic [W-1:0]  THETA_V   = W'(THETA_RH);
    localparam logic [W-1:0]  SH_MAX    = W'(W - 1);
    localparam logic [RW-1:0] REFRAC_V  = RW'(REFRAC);

    typedef enum logic [1:0] {
        BR_SPIKE,
        BR_REFRAC,
        BR_INTEG
    } branch_t;

    logic [W-1:0]  u_mem [N_CH];
    logic [W-1:0]  w_mem [N_CH];
    logic [RW-1:0] r_mem [N_CH];

    logic [W-1:0]    u_cur, w_cur, cur_in;
    logic [RW-1:0]   r_cur;
    branch_t         branch;
    logic [W-1:0]    w_decay, w_spk, leak, ex, ex_sh;
    logic [W:0]      w_sum;
    logic signed [SW-1:0] acc;
    logic [W-1:0]    u_integ;
    logic [W-1:0]    u_nxt, w_nxt;
    logic [RW-1:0]   r_nxt;
    logic [N_CH-1:0] spk_vec;

    assign u_cur     = u_mem[ch_idx];
    assign w_cur     = w_mem[ch_idx];
    assign r_cur     = r_mem[ch_idx];
    assign state_mon = u_cur;

    always_comb begin
        cur_in = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (CW'(c) == ch_idx) cur_in = current[c*W +: W];
        end
    end

    always_comb begin
        w_decay = w_cur - (w_cur >> TAU_W_SHIFT);
        w_sum   = {1'b0, w_decay} + (W+1)'(B);
        w_spk   = w_sum[W] ? '1 : w_sum[W-1:0];

        leak = (u_cur > U_REST_V) ? ((u_cur - U_REST_V) >> LEAK_SHIFT) : '0;

        ex    = '0;
        ex_sh = '0;
        if (u_cur >= THETA_V) begin
            ex_sh = (u_cur - THETA_V) >> DT_SHIFT;
            if (ex_sh > SH_MAX) ex_sh = SH_MAX;
            ex = W'(1) << ex_sh;
        end

        // Widened to W+3 signed so the sum never wraps before clamping.
        acc = $signed({3'b000, u_cur}) - $signed({3'b000, leak})
            + $signed({3'b000, ex}) + $signed({3'b000, cur_in})
            - $signed({3'b000, w_cur});
        if (acc[SW-1])
            u_integ = '0;
        else if (acc[SW-2:W] != '0)
            u_integ = '1;
        else
            u_integ = acc[W-1:0];
    end

    always_comb begin
        if (u_cur >= THRESH_V)
            branch = BR_SPIKE;
        else if (r_cur != '0)
            branch = BR_REFRAC;
        else
            branch = BR_INTEG;

        u_nxt   = u_integ;
        w_nxt   = w_decay;
        r_nxt   = r_cur;
        spk_vec = '0;
        unique case (branch)
            BR_SPIKE: begin
                u_nxt           = V_RESET_V;
                w_nxt           = w_spk;
                r_nxt           = REFRAC_V;
                spk_vec[ch_idx] = 1'b1;
            end
            BR_REFRAC: begin
                u_nxt = V_RESET_V;
                r_nxt = r_cur - RW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                u_mem[c] <= U_REST_V;
                w_mem[c] <= '0;
                r_mem[c] <= '0;
            end
            ch_idx <= '0;
            spike  <= '0;
        end else if (en) begin
            u_mem[ch_idx] <= u_nxt;
            w_mem[ch_idx] <= w_nxt;
            r_mem[ch_idx] <= r_nxt;
            spike         <= spk_vec;
            ch_idx        <= (ch_idx == CW'(N_CH - 1)) ? '0 : ch_idx + CW'(1);
        end else begin
            spike <= '0;
        end
    end

endmodule
